// File: rtl/i2s_channel_scheduler_pkg.sv
// rtl/i2s_channel_scheduler_pkg.sv - shared types and defaults for the I2S channel scheduler
package i2s_channel_scheduler_pkg;

  localparam int SAMPLE_WIDTH       = 24;
  localparam int NUM_AUDIO_CHANNELS = 24;
  localparam int CH_IDX_W           = $clog2(NUM_AUDIO_CHANNELS);

  typedef logic [SAMPLE_WIDTH-1:0] sample_t;
  typedef logic [CH_IDX_W-1:0]     ch_idx_t;

  typedef enum logic {
    IDLE     = 1'b0,
    DISPATCH = 1'b1
  } sched_state_e;

endpackage

// File: rtl/i2s_channel_scheduler_prio_enc.sv
// rtl/i2s_channel_scheduler_prio_enc.sv - combinational lowest-set-bit encoder
module prio_enc_lsb #(
  parameter int WIDTH = 24,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic             found,
  output logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] onehot
);

  // Scan from the top down so the last hit written is the lowest set bit.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = i[IDX_W-1:0];
      end
    end
  end

  // Two's-complement trick isolates the lowest set bit.
  always_comb begin
    onehot = req & (~req + {{(WIDTH-1){1'b0}}, 1'b1});
  end

endmodule

// File: rtl/i2s_channel_scheduler.sv
// rtl/i2s_channel_scheduler.sv - dispatches one captured I2S frame channel by channel to a shared DSP engine
module i2s_channel_scheduler
  import i2s_channel_scheduler_pkg::*;
#(
  parameter int NUM_AUDIO_CHANNELS = i2s_channel_scheduler_pkg::NUM_AUDIO_CHANNELS,
  parameter int SAMPLE_WIDTH       = i2s_channel_scheduler_pkg::SAMPLE_WIDTH,
  localparam int CH_IDX_W          = $clog2(NUM_AUDIO_CHANNELS)
) (
  input  logic                                       sys_clk,
  input  logic                                       sys_rst_n,
  input  logic                                       sample_valid,
  input  logic [NUM_AUDIO_CHANNELS*SAMPLE_WIDTH-1:0] sample_data,
  input  logic [NUM_AUDIO_CHANNELS-1:0]              ch_enable,
  input  logic                                       ovr_clr,
  output logic                                       proc_valid,
  input  logic                                       proc_ready,
  output logic [SAMPLE_WIDTH-1:0]                    proc_data,
  output logic [CH_IDX_W-1:0]                        proc_ch,
  output logic                                       proc_last,
  output logic                                       busy,
  output logic                                       frame_done,
  output logic                                       ovr_pulse,
  output logic [15:0]                                ovr_count
);

  sched_state_e                  state_q, state_d;
  logic [NUM_AUDIO_CHANNELS-1:0] pending_q, pending_d;
  logic [SAMPLE_WIDTH-1:0]       frame_q [NUM_AUDIO_CHANNELS];
  logic [SAMPLE_WIDTH-1:0]       frame_d [NUM_AUDIO_CHANNELS];
  logic                          empty_done_q, empty_done_d;
  logic                          ovr_pulse_q, ovr_pulse_d;
  logic [15:0]                   ovr_count_q, ovr_count_d;

  logic                          enc_found;
  logic [CH_IDX_W-1:0]           enc_idx;
  logic [NUM_AUDIO_CHANNELS-1:0] enc_onehot;

  logic in_dispatch;
  logic xfer;
  logic final_xfer;
  logic accept;
  logic overrun;

  prio_enc_lsb #(
    .WIDTH (NUM_AUDIO_CHANNELS),
    .IDX_W (CH_IDX_W)
  ) u_prio_enc (
    .req    (pending_q),
    .found  (enc_found),
    .idx    (enc_idx),
    .onehot (enc_onehot)
  );

  // Offer side: everything is derived from registered state so it holds steady while stalled.
  always_comb begin
    in_dispatch = (state_q == DISPATCH);
    proc_valid  = in_dispatch & enc_found;
    proc_ch     = enc_idx;
    proc_data   = frame_q[enc_idx];
    proc_last   = proc_valid & ((pending_q & ~enc_onehot) == '0);
    busy        = in_dispatch;
    xfer        = proc_valid & proc_ready;
    final_xfer  = xfer & proc_last;
    // A frame arriving on the last transfer slots in seamlessly; otherwise it collides.
    accept      = sample_valid & (~in_dispatch | final_xfer);
    overrun     = sample_valid & in_dispatch & ~final_xfer;
    frame_done  = empty_done_q | final_xfer;
    ovr_pulse   = ovr_pulse_q;
    ovr_count   = ovr_count_q;
  end

  // Next-state: retire the offered channel, then let an accepted frame override pending.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    empty_done_d = 1'b0;
    if (xfer) begin
      pending_d = pending_q & ~enc_onehot;
    end
    if (final_xfer) begin
      state_d = IDLE;
    end
    if (accept) begin
      pending_d = ch_enable;
      if (ch_enable != '0) begin
        state_d = DISPATCH;
      end else begin
        state_d      = IDLE;
        empty_done_d = 1'b1;
      end
    end
  end

  // Frame buffer only changes when a frame is accepted; dropped frames never touch it.
  always_comb begin
    for (int k = 0; k < NUM_AUDIO_CHANNELS; k++) begin
      frame_d[k] = frame_q[k];
      if (accept) begin
        frame_d[k] = sample_data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      end
    end
  end

  // Overrun bookkeeping: a clear coinciding with an overrun still records that overrun.
  always_comb begin
    ovr_pulse_d = overrun;
    ovr_count_d = ovr_count_q;
    if (ovr_clr) begin
      ovr_count_d = overrun ? 16'd1 : 16'd0;
    end else if (overrun && (ovr_count_q != 16'hFFFF)) begin
      ovr_count_d = ovr_count_q + 16'd1;
    end
  end

  // Control state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      empty_done_q <= 1'b0;
      ovr_pulse_q  <= 1'b0;
      ovr_count_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      empty_done_q <= empty_done_d;
      ovr_pulse_q  <= ovr_pulse_d;
      ovr_count_q  <= ovr_count_d;
    end
  end

  // Frame buffer register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < NUM_AUDIO_CHANNELS; k++) begin
        frame_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_AUDIO_CHANNELS; k++) begin
        frame_q[k] <= frame_d[k];
      end
    end
  end

endmodule

// File: tb/tb_i2s_channel_scheduler.sv
// tb/tb_i2s_channel_scheduler.sv - randomized self-checking bench for i2s_channel_scheduler
module tb_i2s_channel_scheduler;

  localparam int N = 24;
  localparam int W = 24;
  localparam int CW = $clog2(N);

  logic             sys_clk;
  logic             sys_rst_n;
  logic             sample_valid;
  logic [N*W-1:0]   sample_data;
  logic [N-1:0]     ch_enable;
  logic             ovr_clr;
  logic             proc_valid;
  logic             proc_ready;
  logic [W-1:0]     proc_data;
  logic [CW-1:0]    proc_ch;
  logic             proc_last;
  logic             busy;
  logic             frame_done;
  logic             ovr_pulse;
  logic [15:0]      ovr_count;

  int n_vec;
  int n_err;

  // reference model: frame contents, which channels remain, overrun history
  logic [W-1:0] m_buf [N];
  bit           m_pend [N];
  bit           m_busy;
  bit           m_done_empty;
  bit           m_ovr;
  int           m_cnt;

  i2s_channel_scheduler dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .ch_enable    (ch_enable),
    .ovr_clr      (ovr_clr),
    .proc_valid   (proc_valid),
    .proc_ready   (proc_ready),
    .proc_data    (proc_data),
    .proc_ch      (proc_ch),
    .proc_last    (proc_last),
    .busy         (busy),
    .frame_done   (frame_done),
    .ovr_pulse    (ovr_pulse),
    .ovr_count    (ovr_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic int pend_count();
    int c = 0;
    for (int k = 0; k < N; k++) if (m_pend[k]) c++;
    return c;
  endfunction

  function automatic int pend_low();
    for (int k = 0; k < N; k++) if (m_pend[k]) return k;
    return 0;
  endfunction

  // model update: one step of the frame-level rules per clock
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < N; k++) begin
        m_buf[k]  = '0;
        m_pend[k] = 1'b0;
      end
      m_busy = 0; m_done_empty = 0; m_ovr = 0; m_cnt = 0;
    end else begin
      int  cnt;
      int  low;
      bit  fin;
      bit  ovr;
      cnt = pend_count();
      low = pend_low();
      fin = m_busy && proc_ready && (cnt == 1);
      if (m_busy && proc_ready) m_pend[low] = 1'b0;
      ovr = sample_valid && m_busy && !fin;
      m_done_empty = 0;
      if (sample_valid && !ovr) begin
        for (int k = 0; k < N; k++) begin
          m_buf[k]  = sample_data[k*W +: W];
          m_pend[k] = ch_enable[k];
        end
        m_busy = (ch_enable != '0);
        m_done_empty = (ch_enable == '0);
      end else if (fin) begin
        m_busy = 0;
      end
      if (ovr_clr) m_cnt = ovr ? 1 : 0;
      else if (ovr && m_cnt < 65535) m_cnt = m_cnt + 1;
      m_ovr = ovr;
    end
  end

  // per-cycle compare, away from the active edge
  always @(negedge sys_clk) begin
    int  cnt;
    int  low;
    bit  e_last;
    bit  e_done;
    cnt    = pend_count();
    low    = pend_low();
    e_last = m_busy && (cnt == 1);
    e_done = m_done_empty || (m_busy && proc_ready && cnt == 1);
    n_vec++;
    if (proc_valid !== m_busy) begin
      n_err++; $display("FAIL proc_valid t=%0t got %0b want %0b", $time, proc_valid, m_busy);
    end
    if (busy !== m_busy) begin
      n_err++; $display("FAIL busy t=%0t got %0b want %0b", $time, busy, m_busy);
    end
    if (proc_last !== e_last) begin
      n_err++; $display("FAIL proc_last t=%0t got %0b want %0b", $time, proc_last, e_last);
    end
    if (frame_done !== e_done) begin
      n_err++; $display("FAIL frame_done t=%0t got %0b want %0b", $time, frame_done, e_done);
    end
    if (ovr_pulse !== m_ovr) begin
      n_err++; $display("FAIL ovr_pulse t=%0t got %0b want %0b", $time, ovr_pulse, m_ovr);
    end
    if (ovr_count !== 16'(m_cnt)) begin
      n_err++; $display("FAIL ovr_count t=%0t got %0h want %0h", $time, ovr_count, m_cnt);
    end
    if (m_busy) begin
      if (proc_ch !== CW'(low)) begin
        n_err++; $display("FAIL proc_ch t=%0t got %0d want %0d", $time, proc_ch, low);
      end
      if (proc_data !== m_buf[low]) begin
        n_err++; $display("FAIL proc_data t=%0t got %0h want %0h", $time, proc_data, m_buf[low]);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic rand_data();
    for (int k = 0; k < N; k++) sample_data[k*W +: W] = W'($urandom);
  endtask

  task automatic pulse_frame(input logic [N-1:0] en);
    ch_enable    = en;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] exp_d;
    n_vec = 0; n_err = 0;
    sys_rst_n = 1'b0; sample_valid = 1'b0; sample_data = '0;
    ch_enable = '0; ovr_clr = 1'b0; proc_ready = 1'b0;
    repeat (3) tick();
    chk("reset_proc_data", 32'(proc_data), 32'h0);
    chk("reset_proc_ch", 32'(proc_ch), 32'h0);
    sys_rst_n = 1'b1;
    tick();

    // full frame, data ch k = k+1
    for (int k = 0; k < N; k++) sample_data[k*W +: W] = W'(k + 1);
    proc_ready = 1'b1;
    pulse_frame({N{1'b1}});
    chk("t1_first_valid", 32'(proc_valid), 32'h1);
    chk("t1_first_ch", 32'(proc_ch), 32'h0);
    chk("t1_first_data", 32'(proc_data), 32'h1);
    repeat (23) tick();
    chk("t1_last_ch", 32'(proc_ch), 32'd23);
    chk("t1_last_data", 32'(proc_data), 32'd24);
    chk("t1_last_flag", 32'(proc_last), 32'h1);
    chk("t1_done", 32'(frame_done), 32'h1);
    tick();
    chk("t1_idle", 32'(busy), 32'h0);

    // sparse mask 0b101
    rand_data();
    pulse_frame(24'h000005);
    chk("t2_ch0", 32'(proc_ch), 32'd0);
    chk("t2_not_last", 32'(proc_last), 32'h0);
    tick();
    chk("t2_ch2", 32'(proc_ch), 32'd2);
    chk("t2_last", 32'(proc_last), 32'h1);
    tick();
    chk("t2_idle", 32'(busy), 32'h0);

    // empty frame
    pulse_frame('0);
    chk("t3_done", 32'(frame_done), 32'h1);
    chk("t3_novalid", 32'(proc_valid), 32'h0);
    tick();
    chk("t3_done_drop", 32'(frame_done), 32'h0);

    // backpressure pattern 1,0,0,1 repeated
    rand_data();
    pulse_frame(24'h00F0F1);
    for (int i = 0; i < 24; i++) begin
      proc_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    proc_ready = 1'b1;
    repeat (4) tick();

    // overrun at 5th transfer, then seamless accept on final transfer
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    rand_data();
    pulse_frame({N{1'b1}});
    repeat (4) tick();
    rand_data();
    pulse_frame({N{1'b1}});
    chk("t5_ovr_pulse", 32'(ovr_pulse), 32'h1);
    chk("t5_ovr_count", 32'(ovr_count), 32'h1);
    chk("t5_continues", 32'(proc_ch), 32'd5);
    repeat (18) tick();
    chk("t5_at_last", 32'(proc_ch), 32'd23);
    rand_data();
    exp_d = sample_data[W-1:0];
    pulse_frame({N{1'b1}});
    chk("t5_no_ovr", 32'(ovr_pulse), 32'h0);
    chk("t5_new_ch0", 32'(proc_ch), 32'd0);
    chk("t5_new_data", 32'(proc_data), 32'(exp_d));
    repeat (26) tick();

    // saturation, clear-with-overrun, clear alone
    proc_ready = 1'b0;
    rand_data();
    pulse_frame({N{1'b1}});
    sample_valid = 1'b1;
    repeat (65540) tick();
    sample_valid = 1'b0;
    chk("t6_saturate", 32'(ovr_count), 32'hFFFF);
    sample_valid = 1'b1; ovr_clr = 1'b1;
    tick();
    sample_valid = 1'b0; ovr_clr = 1'b0;
    chk("t6_clr_ovr", 32'(ovr_count), 32'h1);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    chk("t6_clr", 32'(ovr_count), 32'h0);

    // async reset mid-frame
    proc_ready = 1'b1;
    repeat (3) tick();
    #2 sys_rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(proc_valid), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_done", 32'(frame_done), 32'h0);
    chk("t6_rst_data", 32'(proc_data), 32'h0);
    tick();
    sys_rst_n = 1'b1;
    tick();
    rand_data();
    pulse_frame({N{1'b1}});
    chk("t6_restart_ch0", 32'(proc_ch), 32'd0);
    repeat (24) tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_data();
      sample_valid = ($urandom % 6 == 0);
      case ($urandom % 4)
        0: ch_enable = '0;
        1: ch_enable = N'(1) << ($urandom % N);
        default: ch_enable = N'($urandom);
      endcase
      proc_ready = ($urandom % 3 != 0);
      ovr_clr    = ($urandom % 20 == 0);
      tick();
    end
    sample_valid = 1'b0; ovr_clr = 1'b0; proc_ready = 1'b1;
    repeat (30) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
